// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage : instruction-decode stage of the 5-stage RV32I pipeline.
//
// Reads the IF/ID register (pc, inst, pc+4). It holds the 32x32 register file
// (written by WB, with write-through to same-cycle reads). It decodes control,
// builds the sign-extended immediate and detects load-use hazards. It also
// owns the ID/EX pipeline register that feeds EX.
//
// Ports
//   clk_i, rst_i            clock; asynchronous active-high reset
//   pc_d_i, inst_d_i,
//   pc4_d_i                 instruction currently in ID
//   flush_i                 EX redirect: kill the ID instruction
//   rd_wb_i, rd_wren_wb_i,
//   rd_data_wb_i            register-file write port from WB
//   stall_o                 combinational load-use stall request to IF
//   *_e_o                   registered ID/EX fields consumed by EX
// -----------------------------------------------------------------------------
module id_stage #(
  parameter logic [31:0] RST_PC   = 32'h0000_0000,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_d_i,
  input  logic [31:0] inst_d_i,
  input  logic [31:0] pc4_d_i,
  input  logic        flush_i,
  input  logic [4:0]  rd_wb_i,
  input  logic        rd_wren_wb_i,
  input  logic [31:0] rd_data_wb_i,
  output logic        stall_o,
  output logic [31:0] pc_e_o,
  output logic [31:0] pc4_e_o,
  output logic [31:0] rs1_data_e_o,
  output logic [31:0] rs2_data_e_o,
  output logic [31:0] imm_e_o,
  output logic [4:0]  rs1_e_o,
  output logic [4:0]  rs2_e_o,
  output logic [4:0]  rd_e_o,
  output logic [3:0]  alu_op_e_o,
  output logic        op_a_sel_e_o,
  output logic        op_b_sel_e_o,
  output logic        is_branch_e_o,
  output logic        is_jump_e_o,
  output logic        br_unsigned_e_o,
  output logic [2:0]  funct3_e_o,
  output logic        mem_rden_e_o,
  output logic        mem_wren_e_o,
  output logic        rd_wren_e_o,
  output logic [1:0]  wb_sel_e_o,
  output logic        insn_vld_e_o
);

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB  = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
    ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
    ALU_OR  = 4'd8, ALU_AND  = 4'd9, ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2} wb_sel_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        op_a_sel;
    logic        op_b_sel;
    logic        is_branch;
    logic        is_jump;
    logic        br_unsigned;
    logic [2:0]  funct3;
    logic        mem_rden;
    logic        mem_wren;
    logic        rd_wren;
    logic [1:0]  wb_sel;
    logic        insn_vld;
  } idex_t;

  // funct3 selects the operation; alt (inst[30]) turns ADD->SUB and SRL->SRA.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [31:0] rf_q [NUM_REGS];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  // NOTE: this memory is reset because x1..x31 must read 0 after reset; a
  // plain RAM without that requirement would normally be left unreset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (rd_wren_wb_i && (rd_wb_i != 5'd0)) begin
      rf_q[rd_wb_i] <= rd_data_wb_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1_f, rs2_f, rd_f;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = inst_d_i[6:0];
  assign funct3 = inst_d_i[14:12];
  assign rs1_f  = inst_d_i[19:15];
  assign rs2_f  = inst_d_i[24:20];
  assign rd_f   = inst_d_i[11:7];

  assign imm_i = {{20{inst_d_i[31]}}, inst_d_i[31:20]};
  assign imm_s = {{20{inst_d_i[31]}}, inst_d_i[31:25], inst_d_i[11:7]};
  assign imm_b = {{19{inst_d_i[31]}}, inst_d_i[31], inst_d_i[7],
                  inst_d_i[30:25], inst_d_i[11:8], 1'b0};
  assign imm_u = {inst_d_i[31:12], 12'h000};
  assign imm_j = {{11{inst_d_i[31]}}, inst_d_i[31], inst_d_i[19:12],
                  inst_d_i[20], inst_d_i[30:21], 1'b0};

  idex_t       dec;
  logic        valid, rs1_used, rs2_used, writes_rd;
  logic [4:0]  rs1_idx, rs2_idx;
  logic [31:0] rs1_rdata, rs2_rdata;

  // Unused source indices are zeroed so EX forwarding never matches them.
  assign rs1_idx = rs1_used ? rs1_f : 5'd0;
  assign rs2_idx = rs2_used ? rs2_f : 5'd0;

  // x0 reads 0; a same-cycle WB write to the read index is passed through.
  assign rs1_rdata = (rs1_idx == 5'd0) ? 32'd0 :
                     (rd_wren_wb_i && (rd_wb_i == rs1_idx)) ? rd_data_wb_i : rf_q[rs1_idx];
  assign rs2_rdata = (rs2_idx == 5'd0) ? 32'd0 :
                     (rd_wren_wb_i && (rd_wb_i == rs2_idx)) ? rd_data_wb_i : rf_q[rs2_idx];

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    dec       = '0;
    valid     = 1'b0;
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OPC_OP: begin
        valid = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1; writes_rd = 1'b1;
        dec.alu_op = alu_from_funct3(funct3, inst_d_i[30]);
      end
      OPC_OPIMM: begin
        valid = 1'b1; rs1_used = 1'b1; writes_rd = 1'b1;
        dec.op_b_sel = 1'b1;
        dec.imm      = imm_i;
        // inst[30] is an immediate bit except for the shift-right encodings.
        dec.alu_op   = alu_from_funct3(funct3, (funct3 == 3'd5) && inst_d_i[30]);
      end
      OPC_LUI: begin
        valid = 1'b1; writes_rd = 1'b1;
        dec.op_b_sel = 1'b1;
        dec.imm      = imm_u;
        dec.alu_op   = ALU_PASSB;
      end
      OPC_AUIPC: begin
        valid = 1'b1; writes_rd = 1'b1;
        dec.op_a_sel = 1'b1;
        dec.op_b_sel = 1'b1;
        dec.imm      = imm_u;
        dec.alu_op   = ALU_ADD;
      end
      OPC_JAL: begin
        valid = 1'b1; writes_rd = 1'b1;
        dec.op_a_sel = 1'b1;
        dec.op_b_sel = 1'b1;
        dec.imm      = imm_j;
        dec.alu_op   = ALU_ADD;
        dec.is_jump  = 1'b1;
        dec.wb_sel   = WB_PC4;
      end
      OPC_JALR: begin
        valid = 1'b1; rs1_used = 1'b1; writes_rd = 1'b1;
        dec.op_b_sel = 1'b1;
        dec.imm      = imm_i;
        dec.alu_op   = ALU_ADD;
        dec.is_jump  = 1'b1;
        dec.wb_sel   = WB_PC4;
      end
      OPC_BRANCH: begin
        valid = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
        dec.op_a_sel    = 1'b1;
        dec.op_b_sel    = 1'b1;
        dec.imm         = imm_b;
        dec.alu_op      = ALU_ADD;
        dec.is_branch   = 1'b1;
        dec.br_unsigned = funct3[1];   // BLTU / BGEU
      end
      OPC_LOAD: begin
        valid = 1'b1; rs1_used = 1'b1; writes_rd = 1'b1;
        dec.op_b_sel = 1'b1;
        dec.imm      = imm_i;
        dec.alu_op   = ALU_ADD;
        dec.mem_rden = 1'b1;
        dec.wb_sel   = WB_MEM;
      end
      OPC_STORE: begin
        valid = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
        dec.op_b_sel = 1'b1;
        dec.imm      = imm_s;
        dec.alu_op   = ALU_ADD;
        dec.mem_wren = 1'b1;
      end
      default: ;
    endcase
    dec.pc       = pc_d_i;
    dec.pc4      = pc4_d_i;
    dec.funct3   = funct3;
    dec.rs1      = rs1_idx;
    dec.rs2      = rs2_idx;
    dec.rs1_data = rs1_rdata;
    dec.rs2_data = rs2_rdata;
    dec.rd       = writes_rd ? rd_f : 5'd0;
    dec.rd_wren  = writes_rd && (rd_f != 5'd0);
    dec.insn_vld = valid;
  end

  // ---------------------------------------------------------------------------
  // Hazard detection and ID/EX register
  // ---------------------------------------------------------------------------
  idex_t idex_q, idex_d;
  logic  load_use;

  assign load_use = idex_q.mem_rden && idex_q.insn_vld && (idex_q.rd != 5'd0) &&
                    ((rs1_used && (rs1_f == idex_q.rd)) ||
                     (rs2_used && (rs2_f == idex_q.rd)));

  // A flush kills the ID instruction anyway, so there is nothing to hold.
  assign stall_o = load_use && !flush_i;

  // Flush, load-use stall and unknown opcodes all issue an all-zero bubble.
  assign idex_d = (flush_i || load_use || !valid) ? '0 : dec;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idex_q     <= '0;
      idex_q.pc  <= RST_PC;
      idex_q.pc4 <= RST_PC + 32'd4;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign pc_e_o          = idex_q.pc;
  assign pc4_e_o         = idex_q.pc4;
  assign rs1_data_e_o    = idex_q.rs1_data;
  assign rs2_data_e_o    = idex_q.rs2_data;
  assign imm_e_o         = idex_q.imm;
  assign rs1_e_o         = idex_q.rs1;
  assign rs2_e_o         = idex_q.rs2;
  assign rd_e_o          = idex_q.rd;
  assign alu_op_e_o      = idex_q.alu_op;
  assign op_a_sel_e_o    = idex_q.op_a_sel;
  assign op_b_sel_e_o    = idex_q.op_b_sel;
  assign is_branch_e_o   = idex_q.is_branch;
  assign is_jump_e_o     = idex_q.is_jump;
  assign br_unsigned_e_o = idex_q.br_unsigned;
  assign funct3_e_o      = idex_q.funct3;
  assign mem_rden_e_o    = idex_q.mem_rden;
  assign mem_wren_e_o    = idex_q.mem_wren;
  assign rd_wren_e_o     = idex_q.rd_wren;
  assign wb_sel_e_o      = idex_q.wb_sel;
  assign insn_vld_e_o    = idex_q.insn_vld;

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage : self-checking bench for id_stage.
// A behavioural model (register array plus per-instruction decode from the
// RV32I rules) predicts the ID/EX contents and stall_o. A compare process
// checks every output on each falling edge. Directed vectors also pin key
// values with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_id_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_d = '0, inst_d = '0, pc4_d = 32'd4;
  logic        flush = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic        wb_wren = 1'b0;
  logic [31:0] wb_data = '0;

  logic        stall;
  logic [31:0] pc_e, pc4_e, rs1_data_e, rs2_data_e, imm_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [3:0]  alu_op_e;
  logic        a_sel_e, b_sel_e, br_e, jmp_e, bru_e;
  logic [2:0]  f3_e;
  logic        rden_e, wren_e, rdw_e;
  logic [1:0]  wb_sel_e;
  logic        vld_e;

  int n_checks = 0;
  int n_fail   = 0;

  id_stage #(.RST_PC(RST_PC), .NUM_REGS(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .pc_d_i(pc_d), .inst_d_i(inst_d), .pc4_d_i(pc4_d), .flush_i(flush),
    .rd_wb_i(wb_rd), .rd_wren_wb_i(wb_wren), .rd_data_wb_i(wb_data),
    .stall_o(stall),
    .pc_e_o(pc_e), .pc4_e_o(pc4_e),
    .rs1_data_e_o(rs1_data_e), .rs2_data_e_o(rs2_data_e), .imm_e_o(imm_e),
    .rs1_e_o(rs1_e), .rs2_e_o(rs2_e), .rd_e_o(rd_e),
    .alu_op_e_o(alu_op_e), .op_a_sel_e_o(a_sel_e), .op_b_sel_e_o(b_sel_e),
    .is_branch_e_o(br_e), .is_jump_e_o(jmp_e), .br_unsigned_e_o(bru_e),
    .funct3_e_o(f3_e), .mem_rden_e_o(rden_e), .mem_wren_e_o(wren_e),
    .rd_wren_e_o(rdw_e), .wb_sel_e_o(wb_sel_e), .insn_vld_e_o(vld_e)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] pc, pc4, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
    logic        a_sel, b_sel, br, jmp, bru;
    logic [2:0]  f3;
    logic        rden, wren, rdw;
    logic [1:0]  wb;
    logic        vld;
  } idex_t;

  localparam logic [6:0] OP = 7'h33, OPIMM = 7'h13, LUI = 7'h37, AUIPC = 7'h17,
                         JAL = 7'h6F, JALR = 7'h67, BRANCH = 7'h63,
                         LOAD = 7'h03, STORE = 7'h23;

  // ALU code per funct3 when inst[30] is clear; inst[30] adds one (ADD->SUB, SRL->SRA).
  logic [3:0]  base_alu [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
  logic [31:0] m_rf [32];
  idex_t       m_idex;

  function automatic logic m_valid(input logic [6:0] opc);
    return opc inside {OP, OPIMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE};
  endfunction

  function automatic logic m_use1(input logic [6:0] opc);
    return m_valid(opc) && !(opc inside {LUI, AUIPC, JAL});
  endfunction

  function automatic logic m_use2(input logic [6:0] opc);
    return opc inside {OP, BRANCH, STORE};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_wren && wb_rd == r) return wb_data;
    return m_rf[r];
  endfunction

  function automatic logic m_hazard();
    logic [6:0] opc = inst_d[6:0];
    return m_idex.vld && m_idex.rden && m_idex.rd != 5'd0 &&
           ((m_use1(opc) && inst_d[19:15] == m_idex.rd) ||
            (m_use2(opc) && inst_d[24:20] == m_idex.rd));
  endfunction

  function automatic idex_t m_decode();
    idex_t       e;
    logic [6:0]  opc    = inst_d[6:0];
    logic [2:0]  f3     = inst_d[14:12];
    logic        writes = !(opc inside {BRANCH, STORE});
    logic [31:0] imm_i  = 32'($signed(inst_d[31:20]));
    logic [31:0] imm_s  = 32'($signed({inst_d[31:25], inst_d[11:7]}));
    logic [31:0] imm_b  = 32'($signed({inst_d[31], inst_d[7], inst_d[30:25], inst_d[11:8], 1'b0}));
    logic [31:0] imm_u  = {inst_d[31:12], 12'h000};
    logic [31:0] imm_j  = 32'($signed({inst_d[31], inst_d[19:12], inst_d[20], inst_d[30:21], 1'b0}));
    e = '0;
    e.pc = pc_d; e.pc4 = pc4_d; e.f3 = f3; e.vld = 1'b1;
    case (opc)
      OP:     e.alu = base_alu[f3] + 4'((f3 == 3'd0 || f3 == 3'd5) && inst_d[30]);
      OPIMM:  begin e.b_sel = 1; e.imm = imm_i; e.alu = base_alu[f3] + 4'(f3 == 3'd5 && inst_d[30]); end
      LUI:    begin e.b_sel = 1; e.imm = imm_u; e.alu = 4'd10; end
      AUIPC:  begin e.a_sel = 1; e.b_sel = 1; e.imm = imm_u; end
      JAL:    begin e.a_sel = 1; e.b_sel = 1; e.imm = imm_j; e.jmp = 1; e.wb = 2'd2; end
      JALR:   begin e.b_sel = 1; e.imm = imm_i; e.jmp = 1; e.wb = 2'd2; end
      BRANCH: begin e.a_sel = 1; e.b_sel = 1; e.imm = imm_b; e.br = 1; e.bru = (f3 == 3'd6 || f3 == 3'd7); end
      LOAD:   begin e.b_sel = 1; e.imm = imm_i; e.rden = 1; e.wb = 2'd1; end
      STORE:  begin e.b_sel = 1; e.imm = imm_s; e.wren = 1; end
      default: ;
    endcase
    e.rs1  = m_use1(opc) ? inst_d[19:15] : 5'd0;
    e.rs2  = m_use2(opc) ? inst_d[24:20] : 5'd0;
    e.rs1d = m_read(e.rs1);
    e.rs2d = m_read(e.rs2);
    e.rd   = writes ? inst_d[11:7] : 5'd0;
    e.rdw  = writes && inst_d[11:7] != 5'd0;
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    idex_t nxt;
    if (rst) begin
      m_idex     = '0;
      m_idex.pc  = RST_PC;
      m_idex.pc4 = RST_PC + 32'd4;
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
    end else begin
      nxt = (flush || m_hazard() || !m_valid(inst_d[6:0])) ? '0 : m_decode();
      if (wb_wren && wb_rd != 5'd0) m_rf[wb_rd] = wb_data;
      m_idex = nxt;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    check("stall_o",         32'(stall),      32'(m_hazard() && !flush));
    check("pc_e_o",          pc_e,            m_idex.pc);
    check("pc4_e_o",         pc4_e,           m_idex.pc4);
    check("rs1_data_e_o",    rs1_data_e,      m_idex.rs1d);
    check("rs2_data_e_o",    rs2_data_e,      m_idex.rs2d);
    check("imm_e_o",         imm_e,           m_idex.imm);
    check("rs1_e_o",         32'(rs1_e),      32'(m_idex.rs1));
    check("rs2_e_o",         32'(rs2_e),      32'(m_idex.rs2));
    check("rd_e_o",          32'(rd_e),       32'(m_idex.rd));
    check("alu_op_e_o",      32'(alu_op_e),   32'(m_idex.alu));
    check("op_a_sel_e_o",    32'(a_sel_e),    32'(m_idex.a_sel));
    check("op_b_sel_e_o",    32'(b_sel_e),    32'(m_idex.b_sel));
    check("is_branch_e_o",   32'(br_e),       32'(m_idex.br));
    check("is_jump_e_o",     32'(jmp_e),      32'(m_idex.jmp));
    check("br_unsigned_e_o", 32'(bru_e),      32'(m_idex.bru));
    check("funct3_e_o",      32'(f3_e),       32'(m_idex.f3));
    check("mem_rden_e_o",    32'(rden_e),     32'(m_idex.rden));
    check("mem_wren_e_o",    32'(wren_e),     32'(m_idex.wren));
    check("rd_wren_e_o",     32'(rdw_e),      32'(m_idex.rdw));
    check("wb_sel_e_o",      32'(wb_sel_e),   32'(m_idex.wb));
    check("insn_vld_e_o",    32'(vld_e),      32'(m_idex.vld));
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  localparam logic [31:0] NOP_INV   = 32'h0000_0000;  // opcode 0: bubble
  localparam logic [31:0] ADD_6_5_0 = 32'h0002_8333;  // add  x6,x5,x0
  localparam logic [31:0] ADD_9_0_0 = 32'h0000_04B3;  // add  x9,x0,x0
  localparam logic [31:0] LW_7      = 32'h0000_A383;  // lw   x7,0(x1)
  localparam logic [31:0] LW_0      = 32'h0000_A003;  // lw   x0,0(x1)
  localparam logic [31:0] LW_9      = 32'h0000_A483;  // lw   x9,0(x1)
  localparam logic [31:0] SW_9      = 32'h0091_2023;  // sw   x9,0(x2)
  localparam logic [31:0] ADDI_8_7  = 32'h0013_8413;  // addi x8,x7,1
  localparam logic [31:0] ADDI_8_0  = 32'h0010_0413;  // addi x8,x0,1
  localparam logic [31:0] LUI_7     = 32'h1234_53B7;  // lui  x7,0x12345
  localparam logic [31:0] BEQ_M8    = 32'hFE20_8CE3;  // beq  x1,x2,-8

  // Mixed instructions checked only by the model.
  logic [31:0] mix [10] = '{
    32'h0020_A223,   // sw   x2,4(x1)
    32'h0100_00EF,   // jal  x1,16
    32'h0000_8067,   // jalr x0,0(x1)
    32'h0000_1197,   // auipc x3,1
    32'h4031_5213,   // srai x4,x2,3
    32'h4020_82B3,   // sub  x5,x1,x2
    32'h0020_B333,   // sltu x6,x1,x2
    32'h0020_E463,   // bltu x1,x2,8
    32'hFFF0_0193,   // addi x3,x0,-1
    32'hFFFF_FFFF    // unknown opcode
  };

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
    @(posedge clk);
    #1;
    inst_d  = inst;
    pc_d    = pc;
    pc4_d   = pc + 32'd4;
    flush   = 1'b0;
    wb_wren = 1'b0;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] data);
    wb_rd   = rd;
    wb_data = data;
    wb_wren = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("reset pc_e_o",  pc_e,  32'h0);
    check("reset pc4_e_o", pc4_e, 32'h4);
    check("reset vld",     32'(vld_e), 32'h0);
    check("reset stall_o", 32'(stall), 32'h0);
    rst = 1'b0;

    // Preload registers
    drive(NOP_INV, 32'h0); wb(5'd1, 32'h0000_0100);
    drive(NOP_INV, 32'h0); wb(5'd2, 32'h0000_0200);
    drive(NOP_INV, 32'h0); wb(5'd7, 32'h0000_0077);

    // WB write-through into a same-cycle read
    drive(ADD_6_5_0, 32'h10); wb(5'd5, 32'hDEAD_BEEF);
    drive(NOP_INV, 32'h14); #1;
    check("bypass rs1_data", rs1_data_e, 32'hDEAD_BEEF);
    check("bypass rs2_data", rs2_data_e, 32'h0);
    check("bypass rd_e_o",   32'(rd_e),  32'd6);

    // x0 stays zero, both on the same-cycle path and afterwards
    drive(ADD_9_0_0, 32'h18); wb(5'd0, 32'hFFFF_FFFF);
    drive(ADD_9_0_0, 32'h1C); #1;
    check("x0 same-cycle", rs1_data_e, 32'h0);
    drive(NOP_INV, 32'h20); #1;
    check("x0 after write", rs1_data_e, 32'h0);

    // Load-use stall with a WB write during the stall cycle
    drive(LW_7, 32'h24);
    drive(ADDI_8_7, 32'h28); wb(5'd7, 32'h0000_0055); #1;
    check("load-use stall_o", 32'(stall), 32'h1);
    drive(ADDI_8_7, 32'h28); #1;
    check("stall bubble vld", 32'(vld_e), 32'h0);
    check("stall released",   32'(stall), 32'h0);
    drive(NOP_INV, 32'h2C); #1;
    check("addi vld",      32'(vld_e), 32'h1);
    check("addi rs1_e_o",  32'(rs1_e), 32'd7);
    check("addi imm_e_o",  imm_e,      32'h1);
    check("addi new x7",   rs1_data_e, 32'h0000_0055);

    // LUI does not read rs1: no stall
    drive(LW_7, 32'h30);
    drive(LUI_7, 32'h34); #1;
    check("lui no stall", 32'(stall), 32'h0);
    drive(NOP_INV, 32'h38); #1;
    check("lui imm_e_o",    imm_e,         32'h1234_5000);
    check("lui alu_op_e_o", 32'(alu_op_e), 32'd10);

    // Load into x0 never stalls
    drive(LW_0, 32'h3C);
    drive(ADDI_8_0, 32'h40); #1;
    check("lw x0 no stall", 32'(stall), 32'h0);

    // Store data (rs2) hazard
    drive(LW_9, 32'h44);
    drive(SW_9, 32'h48); #1;
    check("rs2 stall_o", 32'(stall), 32'h1);
    drive(SW_9, 32'h48);

    // Flush beats stall
    drive(LW_7, 32'h50);
    drive(ADDI_8_7, 32'h54); flush = 1'b1; #1;
    check("flush stall_o", 32'(stall), 32'h0);
    drive(NOP_INV, 32'h58); #1;
    check("flush bubble vld",  32'(vld_e),  32'h0);
    check("flush bubble rdw",  32'(rdw_e),  32'h0);
    check("flush bubble rden", 32'(rden_e), 32'h0);

    // Flush of an ordinary instruction
    drive(ADD_6_5_0, 32'h5C); flush = 1'b1;

    // Branch decode
    drive(BEQ_M8, 32'h60);
    drive(NOP_INV, 32'h64); #1;
    check("beq imm_e_o",     imm_e,        32'hFFFF_FFF8);
    check("beq is_branch",   32'(br_e),    32'h1);
    check("beq op_a_sel",    32'(a_sel_e), 32'h1);
    check("beq rd_wren",     32'(rdw_e),   32'h0);
    check("beq pc_e_o",      pc_e,         32'h60);

    // Mixed instructions
    for (int i = 0; i < 10; i++) drive(mix[i], 32'h100 + 32'(i * 4));

    // Reset while stalling
    drive(LW_7, 32'h200);
    drive(ADDI_8_7, 32'h204); #1;
    check("pre-reset stall_o", 32'(stall), 32'h1);
    rst = 1'b1; #1;
    check("mid-reset stall_o", 32'(stall),  32'h0);
    check("mid-reset pc_e_o",  pc_e,        RST_PC);
    check("mid-reset pc4_e_o", pc4_e,       32'h4);
    check("mid-reset vld",     32'(vld_e),  32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // x1..x31 read zero after reset (add x0,xi,xi)
    for (int i = 1; i <= 32; i++) begin
      drive((i <= 31) ? {7'd0, 5'(i), 5'(i), 3'd0, 5'd0, 7'h33} : NOP_INV, 32'h300 + 32'(i * 4));
      #1;
      if (i > 1) begin
        check("post-reset rs1_data", rs1_data_e, 32'h0);
        check("post-reset rs2_data", rs2_data_e, 32'h0);
      end
    end

    drive(NOP_INV, 32'h400);
    @(posedge clk); @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage RV32I pipeline, directly downstream of the fetch stage.
- Consumes the IF/ID register outputs (pc, inst, pc+4). Holds the 32x32 register file, which is written by WB.
- Decodes control, generates the immediate, detects load-use hazards (stalls IF), and owns the ID/EX pipeline register feeding EX.

Parameters:
RST_PC, 32'h0000_0000, value loaded into pc_e_o/pc4_e_o on reset
NUM_REGS, 32, register-file depth (fixed at 32 for RV32I; index width 5)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous, active-high reset
pc_d_i  in  32  PC of instruction in ID
inst_d_i  in  32  instruction in ID
pc4_d_i  in  32  PC+4 of instruction in ID
flush_i  in  1  EX resolved taken branch/jump; kill instruction in ID
rd_wb_i  in  5  WB destination index
rd_wren_wb_i  in  1  WB write enable
rd_data_wb_i  in  32  WB write data
stall_o  out  1  hold PC and IF/ID register this cycle (combinational)
pc_e_o, pc4_e_o  out  32  registered PC, PC+4
rs1_data_e_o, rs2_data_e_o  out  32  registered operand data
imm_e_o  out  32  registered sign-extended immediate
rs1_e_o, rs2_e_o, rd_e_o  out  5  registered register indices (for EX forwarding)
alu_op_e_o  out  4  0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 PASSB
op_a_sel_e_o  out  1  0 rs1, 1 pc
op_b_sel_e_o  out  1  0 rs2, 1 imm
is_branch_e_o, is_jump_e_o, br_unsigned_e_o  out  1  branch class, JAL/JALR, BLTU/BGEU
funct3_e_o  out  3  branch condition / load-store size
mem_rden_e_o, mem_wren_e_o, rd_wren_e_o  out  1  load, store, register writeback
wb_sel_e_o  out  2  0 ALU, 1 memory, 2 pc+4
insn_vld_e_o  out  1  0 = bubble

Behaviour:
- Reset: asynchronous, active-high. All 32 registers are cleared. Every ID/EX output is 0, except pc_e_o=RST_PC and pc4_e_o=RST_PC+4. stall_o reflects the zeroed ID/EX register, so it is 0.
- Latency: an instruction presented at inst_d_i appears on the _e_o outputs one cycle later.
- Register file:
  - Write at the rising edge when rd_wren_wb_i=1 and rd_wb_i!=0.
  - x0 always reads 0.
  - Write-through: if rd_wren_wb_i=1 and rd_wb_i==rs (rs!=0), the read returns rd_data_wb_i in the same cycle.
- Decode, by opcode:
  - OP: op_b=rs2.
  - OP-IMM: op_b=imm. SRAI/SRLI selected by inst[30].
  - LUI: PASSB, imm.
  - AUIPC: op_a=pc, ADD.
  - JAL: op_a=pc, jump, wb_sel=2.
  - JALR: op_a=rs1, jump, wb_sel=2.
  - BRANCH: op_a=pc, imm, ADD, is_branch.
  - LOAD: mem_rden, wb_sel=1.
  - STORE: mem_wren, rd_wren=0.
  - Any other opcode: bubble (all controls 0, insn_vld=0).
  - rd_wren is forced 0 when rd=0.
- Immediates: I, S, B, U, J formats, sign-extended from inst[31]. B/J bit0=0. U low 12 bits=0.
- Hazard detection: stall_o=1 when all of the following hold:
  - mem_rden_e_o=1, insn_vld_e_o=1, rd_e_o!=0;
  - rd_e_o equals an rs actually used by the ID instruction. rs1 is unused by LUI/AUIPC/JAL. rs2 is used only by OP/BRANCH/STORE.
- Stall: ID/EX loads a bubble; the ID instruction is re-decoded next cycle (IF holds).
- Flush: flush_i=1 loads a bubble into ID/EX and forces stall_o=0. Flush has priority over stall.
- Bubble contents: insn_vld, rd_wren, mem_rden, mem_wren, is_branch, is_jump all 0. Data fields don't-care (implement as 0).
- Simultaneous WB write and stall: the write still occurs. The re-decoded instruction sees the new value.
- Reset mid-stall: stall_o drops immediately, because the ID/EX register clears asynchronously.

Test Plan:
- Reset asserted mid-run -> all _e_o 0, pc_e_o=0, pc4_e_o=4, stall_o=0, x1..x31 read 0.
- WB write x5=0xDEADBEEF, same cycle ID decodes "add x6,x5,x0" -> next cycle rs1_data_e_o=0xDEADBEEF (bypass), rs2_data_e_o=0.
- "lw x7,0(x1)" followed by "addi x8,x7,1" -> one cycle stall_o=1, one bubble (insn_vld_e_o=0), then addi issues with rs1_e_o=7, imm_e_o=1.
- "lw x7,0(x1)" followed by "lui x7,0x12345" -> no stall; imm_e_o=0x12345000, alu_op_e_o=10.
- Stall condition present with flush_i=1 -> stall_o=0, bubble in ID/EX.
- "beq x1,x2,-8" (inst 0xFE208CE3) -> imm_e_o=0xFFFFFFF8, is_branch_e_o=1, op_a_sel_e_o=1, rd_wren_e_o=0.
- Write to x0 with 0xFFFFFFFF -> x0 still reads 0.
